// File: rtl/visor_hex_digitos.sv
// visor_hex_digitos: rate-limited capture of six BCD digits onto six active-low 7-segment displays
// Ports: clk/reset (async, active-high); digit0..digit5 BCD in (digit0 = LSD), valid, overflow,
//        congelar (freeze); HEX0..HEX5 active-low {g,f,e,d,c,b,a}; actualizado = one-cycle new-value pulse
module visor_hex_digitos #(
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter bit BLANK_LEADING  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic [3:0] digit5,
    input  logic       valid,
    input  logic       overflow,
    input  logic       congelar,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       actualizado
);
    // a 1-cycle refresh still needs a 1-bit counter that simply stays at 0
    localparam int CW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d, ovf_q, ovf_d, upd_q, upd_d, act_q, act_d;
    logic [3:0]    din [6];
    logic [3:0]    dig_q [6];
    logic [3:0]    dig_d [6];
    logic [6:0]    hex_q [6];
    logic [6:0]    hex_d [6];
    logic [5:0]    nz;
    logic          tc, cap;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0000110;
        endcase
    endfunction

    assign din = '{digit0, digit1, digit2, digit3, digit4, digit5};

    always_comb begin
        tc     = cnt_q == CW'(REFRESH_CYCLES - 1);
        cap    = (pend_q | tc) & valid & ~congelar;
        cnt_d  = tc ? '0 : cnt_q + CW'(1);
        // capture wins over a simultaneous terminal count; tc keeps arming during a freeze
        pend_d = cap ? 1'b0 : (tc | pend_q);
        ovf_d  = cap ? overflow : ovf_q;
        upd_d  = cap;
        act_d  = upd_q;
        for (int k = 0; k < 6; k++) begin
            dig_d[k] = cap ? din[k] : dig_q[k];
            // nz[k]: some held digit at position k or above is non-zero (codes >9 included)
            nz[k] = 1'b0;
            for (int j = k; j < 6; j++) nz[k] = nz[k] | (dig_q[j] != 4'd0);
            hex_d[k] = !upd_q ? hex_q[k] :
                       ovf_q ? 7'b0111111 :
                       (BLANK_LEADING && k != 0 && !nz[k]) ? 7'b1111111 : seg7(dig_q[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b1;
            ovf_q  <= 1'b0;
            upd_q  <= 1'b0;
            act_q  <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                dig_q[k] <= 4'd0;
                hex_q[k] <= 7'b1111111;
            end
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            upd_q  <= upd_d;
            act_q  <= act_d;
            for (int k = 0; k < 6; k++) begin
                dig_q[k] <= dig_d[k];
                hex_q[k] <= hex_d[k];
            end
        end
    end

    assign HEX0        = hex_q[0];
    assign HEX1        = hex_q[1];
    assign HEX2        = hex_q[2];
    assign HEX3        = hex_q[3];
    assign HEX4        = hex_q[4];
    assign HEX5        = hex_q[5];
    assign actualizado = act_q;
endmodule

// File: tb/tb_visor_hex_digitos.sv
// tb_visor_hex_digitos: scoreboard bench for visor_hex_digitos (blanking and non-blanking instances)
module tb_visor_hex_digitos;
    localparam int R = 8;
    localparam logic [41:0] DARK = {6{7'b1111111}};
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        logic [41:0] ea;
        logic [41:0] eb;
        int          due;
    } exp_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic [3:0] d [6];
    logic       valid = 1'b0, overflow = 1'b0, congelar = 1'b0;
    logic [6:0] ha [6];
    logic [6:0] hb [6];
    logic       acta, actb;
    exp_t       q[$];
    int         ntot = 0, npass = 0, tcyc = 0, ncap = 0;
    logic [41:0] cur_a = DARK, cur_b = DARK;

    always #5 clk = ~clk;

    visor_hex_digitos #(.REFRESH_CYCLES(R), .BLANK_LEADING(1)) u_a (
        .clk(clk), .reset(reset), .digit0(d[0]), .digit1(d[1]), .digit2(d[2]), .digit3(d[3]),
        .digit4(d[4]), .digit5(d[5]), .valid(valid), .overflow(overflow), .congelar(congelar),
        .HEX0(ha[0]), .HEX1(ha[1]), .HEX2(ha[2]), .HEX3(ha[3]), .HEX4(ha[4]), .HEX5(ha[5]),
        .actualizado(acta));

    visor_hex_digitos #(.REFRESH_CYCLES(R), .BLANK_LEADING(0)) u_b (
        .clk(clk), .reset(reset), .digit0(d[0]), .digit1(d[1]), .digit2(d[2]), .digit3(d[3]),
        .digit4(d[4]), .digit5(d[5]), .valid(valid), .overflow(overflow), .congelar(congelar),
        .HEX0(hb[0]), .HEX1(hb[1]), .HEX2(hb[2]), .HEX3(hb[3]), .HEX4(hb[4]), .HEX5(hb[5]),
        .actualizado(actb));

    // what a person should read on the six displays for a captured digit set
    function automatic logic [41:0] model(input logic [3:0] dd [6], input logic ovf, input bit bl);
        logic [41:0] r;
        int msd = 0;
        for (int k = 0; k < 6; k++) if (dd[k] != 0) msd = k;
        for (int k = 0; k < 6; k++)
            r[k*7 +: 7] = ovf ? 7'b0111111 : (bl && k > msd) ? 7'b1111111 :
                          (dd[k] > 9) ? 7'b0000110 : SEG[dd[k]];
        return r;
    endfunction

    function automatic logic [41:0] pack(input logic [6:0] h [6]);
        logic [41:0] r;
        for (int k = 0; k < 6; k++) r[k*7 +: 7] = h[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: one capture allowed per refresh window, first one after reset is immediate
    initial begin
        bit pend, tc, c;
        int cyc;
        pend = 1; cyc = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                pend = 1; cyc = 0;
                q.delete();
            end else begin
                tc = (cyc % R) == R - 1;
                c  = (pend || tc) && valid && !congelar;
                if (c) begin
                    q.push_back('{model(d, overflow, 1), model(d, overflow, 0), tcyc + 2});
                    ncap++;
                end
                pend = c ? 0 : (tc ? 1 : pend);
                cyc++;
                tcyc++;
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur_a = DARK; cur_b = DARK;
                chk("reset_hex_a", pack(ha), DARK);
                chk("reset_hex_b", pack(hb), DARK);
                chk("reset_act", {40'd0, acta, actb}, 42'd0);
            end else if (acta || actb) begin
                chk("act_agree", {41'd0, acta}, {41'd0, actb});
                if (q.size() == 0) begin
                    chk("unexpected_update", {41'd0, acta}, 42'd0);
                end else begin
                    e = q.pop_front();
                    chk("update_latency", 42'(tcyc), 42'(e.due));
                    chk("update_hex_a", pack(ha), e.ea);
                    chk("update_hex_b", pack(hb), e.eb);
                    cur_a = e.ea; cur_b = e.eb;
                end
            end else begin
                if (q.size() != 0 && q[0].due < tcyc) begin
                    chk("missing_update", 42'(tcyc), 42'(q[0].due));
                    void'(q.pop_front());
                end
                chk("stable_a", pack(ha), cur_a);
                chk("stable_b", pack(hb), cur_b);
            end
        end
    end

    initial begin
        logic [41:0] snap;
        int c0;
        for (int k = 0; k < 6; k++) d[k] = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // digit5..digit0 = 0,1,2,3,4,5 captured immediately after reset
        d = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        valid = 1'b1;
        step();
        valid = 1'b0;
        step(); step(); step();
        chk("t1_hex5", {35'd0, ha[5]}, {35'd0, 7'b1111111});
        chk("t1_hex4", {35'd0, ha[4]}, {35'd0, 7'b1111001});
        chk("t1_hex3", {35'd0, ha[3]}, {35'd0, 7'b0100100});
        chk("t1_hex2", {35'd0, ha[2]}, {35'd0, 7'b0110000});
        chk("t1_hex1", {35'd0, ha[1]}, {35'd0, 7'b0011001});
        chk("t1_hex0", {35'd0, ha[0]}, {35'd0, 7'b0010010});
        // continuous valid with changing digits
        valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 6; k++) d[k] = 4'($urandom % 10);
            step();
        end
        // all zeros
        for (int k = 0; k < 6; k++) d[k] = 4'd0;
        repeat (9) step();
        valid = 1'b0;
        step(); step(); step();
        chk("zero_blank", pack(ha), {{5{7'b1111111}}, 7'b1000000});
        chk("zero_noblank", pack(hb), {6{7'b1000000}});
        // overflow
        valid = 1'b1; overflow = 1'b1;
        for (int k = 0; k < 6; k++) d[k] = 4'($urandom % 16);
        repeat (9) step();
        valid = 1'b0;
        step(); step(); step();
        chk("overflow_dash", pack(ha), {6{7'b0111111}});
        // invalid digit shows E
        valid = 1'b1; overflow = 1'b0;
        for (int k = 0; k < 6; k++) d[k] = 4'($urandom % 10);
        d[3] = 4'hC;
        repeat (9) step();
        valid = 1'b0;
        step(); step(); step();
        chk("digit_E", {35'd0, ha[3]}, {35'd0, 7'b0000110});
        // freeze over three refresh periods
        snap = pack(ha);
        congelar = 1'b1;
        for (int i = 0; i < 3 * R; i++) begin
            valid = 1'($urandom % 2);
            for (int k = 0; k < 6; k++) d[k] = 4'($urandom % 10);
            step();
        end
        chk("freeze_hold", pack(ha), snap);
        congelar = 1'b0; valid = 1'b1;
        d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        step();
        valid = 1'b0;
        step();
        chk("freeze_release_upd", {41'd0, acta}, 42'd1);
        chk("freeze_release_hex", pack(ha), model(d, 1'b0, 1));
        // reset one cycle after a capture
        valid = 1'b1;
        c0 = ncap;
        for (int i = 0; i < 3 * R && ncap == c0; i++) begin
            for (int k = 0; k < 6; k++) d[k] = 4'($urandom % 10);
            step();
        end
        chk("capture_seen", 42'(ncap != c0), 42'd1);
        valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_async_hex", pack(ha), DARK);
        chk("reset_async_act", {41'd0, acta}, 42'd0);
        step(); step();
        reset = 1'b0; valid = 1'b1;
        d = '{4'd9, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
        step();
        valid = 1'b0;
        step();
        chk("post_reset_upd", {41'd0, acta}, 42'd1);
        chk("post_reset_hex", pack(ha), {{4{7'b1111111}}, 7'b0000000, 7'b0010000});
        // random traffic
        for (int i = 0; i < 300; i++) begin
            valid    = ($urandom % 3) != 0;
            congelar = ($urandom % 5) == 0;
            overflow = ($urandom % 8) == 0;
            for (int k = 0; k < 6; k++) d[k] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
            step();
        end
        valid = 1'b0; congelar = 1'b0; overflow = 1'b0;
        repeat (12) step();
        chk("drain", 42'(q.size()), 42'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/visor_hex_digitos.md
# visor_hex_digitos

Display stage that consumes the six BCD digits of the decimal decomposer and drives six active-low seven-segment displays (HEX0..HEX5). It captures a digit set at most once per refresh period so a fast-changing measurement stays readable, and supports freeze, leading-zero blanking, overflow indication and invalid-digit indication. Outputs are registered and glitch-free, and go directly to the board pins.

## Interface
- REFRESH_CYCLES, 5_000_000, refresh period in clk cycles (10 Hz at 50 MHz); legal range 1..2^26
- BLANK_LEADING, 1, 1 = blank leading zeros on HEX5..HEX1; 0 = show all digits
- clk  in  1  system clock; all state is on the rising edge
- reset  in  1  asynchronous, active-high reset
- digit0..digit5  in  4 each  BCD digits from the decomposer; digit0 is the least significant
- valid  in  1  the digits and overflow are valid this cycle
- overflow  in  1  the source number exceeds 999999; sampled together with the digits
- congelar  in  1  freeze: while high, no new capture occurs
- HEX0..HEX5  out  7 each  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- actualizado  out  1  one-cycle pulse marking the first cycle in which new HEX values are visible

## Operation
- Refresh counter `cnt`, width clog2(REFRESH_CYCLES):
  - free-runs 0..REFRESH_CYCLES-1 and wraps to 0
  - terminal count tc = (cnt == REFRESH_CYCLES-1)
- `pendiente` flag:
  - set on tc
  - cleared on capture
  - reset value 1, so the first valid after reset is captured immediately
- Capture condition: cap = (pendiente | tc) & valid & ~congelar.
  - On cap, latch digit0..5 and overflow into the hold registers.
  - Capture and clear take priority over a simultaneous tc set.
- congelar high: cap is suppressed and pendiente is held. The first valid after congelar falls is captured if pendiente=1.
- REFRESH_CYCLES=1: tc is always 1, so every valid with ~congelar is captured.
- Encoding applied to the held digit k (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - values 10..15 show 'E' = 0000110
- Leading-zero blanking (BLANK_LEADING=1):
  - HEXk for k≥1 shows 1111111 when the held digits k..5 are all zero.
  - HEX0 is never blanked; a value of 0 displays as a single '0'.
  - Invalid digits (>9) count as non-zero.
- Overflow held: all six HEX show '-' = 0111111. This overrides blanking and 'E'.
- HEX registers load the encoded value in the cycle after a capture. actualizado is registered alongside them.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-refresh or mid-update):
  - HEX0..HEX5 = 1111111 (all dark)
  - actualizado = 0, cnt = 0, hold registers = 0, held overflow = 0, pendiente = 1
- Latency: cap true in cycle N → hold registers update at the end of cycle N → HEX registers update at the end of cycle N+1.
  - New HEX values and actualizado=1 are visible in cycle N+2.
  - actualizado is exactly one cycle wide.
- Maximum update rate: one capture per REFRESH_CYCLES cycles, except the first capture after reset.
- Between captures, HEX outputs are stable regardless of digit/valid activity.
- No backpressure; valid pulses arriving while pendiente=0 are dropped.

## Test plan
Run with REFRESH_CYCLES=8, BLANK_LEADING=1 unless noted.
- Reset, then valid=1 with digits 5,4,3,2,1,0 (digit5..digit0 = 0,1,2,3,4,5):
  - HEX5 = 1111111
  - HEX4..HEX0 = 1111001, 0100100, 0110000, 0011001, 0010010
  - actualizado pulses 2 cycles after valid
- Continuous valid with changing digits: HEX changes exactly once every 8 cycles; actualizado period is 8.
- All digits zero:
  - HEX5..HEX1 = 1111111, HEX0 = 1000000
  - with BLANK_LEADING=0, all six = 1000000
- overflow=1 with any digits: all HEX = 0111111. With digit3=4'hC and overflow=0: HEX3 = 0000110.
- Freeze:
  - congelar=1 over 3 refresh periods with valid pulses: no HEX change, no actualizado
  - drop congelar with valid=1: capture in that cycle, HEX updated 2 cycles later
- Reset mid-operation: assert reset 1 cycle after a capture. All HEX go to 1111111 immediately, no actualizado pulse; the next valid after release is captured at once.
